// File: rtl/dbg_ocimem_pkg.sv
// Shared debug definitions: controller FSM states and the field layout of
// the 38-bit jdo word handed over by the JTAG debug slave.
package dbg_ocimem_pkg;

    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;

    localparam int JDO_W       = 38;
    localparam int JDO_RD_BIT  = 35;
    localparam int JDO_ADDR_HI = 33;
    localparam int JDO_ADDR_LO = 26;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;
    localparam int JDO_ADDR_W  = JDO_ADDR_HI - JDO_ADDR_LO + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_JT_OP,
        ST_JT_DONE,
        ST_AV_OP,
        ST_AV_DONE
    } ocimem_state_t;

    function automatic logic [JDO_ADDR_W-1:0] jdo_addr(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_ADDR_HI:JDO_ADDR_LO];
    endfunction

    function automatic logic [DATA_W-1:0] jdo_data(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_DATA_HI:JDO_DATA_LO];
    endfunction

    function automatic logic jdo_rd(input logic [JDO_W-1:0] jdo);
        return jdo[JDO_RD_BIT];
    endfunction

endpackage

// File: rtl/dbg_ocimem.sv
// dbg_ocimem block index: the design is split across dbg_ocimem_pkg,
// dbg_ocimem_ram and the dbg_ocimem_ctrl top level.

// File: rtl/dbg_ocimem_ram.sv
// Single-port 32-bit RAM with per-byte write enables and one-cycle
// registered read (read-before-write on the same address).
module dbg_ocimem_ram
    import dbg_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Byte-masked write and registered read of the addressed word.
    // NOTE: the array has no reset on purpose; contents must survive a
    // controller reset, and a reset port would block block-RAM inference.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dbg_ocimem_ctrl.sv
// On-chip instruction memory controller shared between the JTAG debug
// slave (one-deep pending request) and an Avalon slave port.  JTAG wins
// arbitration; Avalon accesses complete two cycles after acceptance.
module dbg_ocimem_ctrl
    import dbg_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic              debugaccess,
    input  logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready
);

    ocimem_state_t     state;
    logic [ADDR_W-1:0] jtag_addr;
    logic              jt_pend;
    logic              jt_pend_wr;
    logic              jt_op_rd;

    logic [ADDR_W-1:0] av_addr;
    logic              av_wr;
    logic              av_dbg;
    logic [BE_W-1:0]   av_be;
    logic [DATA_W-1:0] av_wdata;
    logic [DATA_W-1:0] rd_hold;

    logic              ram_en;
    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] av_rdata;

    logic              jt_new;
    logic              av_req;
    logic              jdo_unused;

    // A pulse in the same cycle as an Avalon request must still win, so the
    // idle decision looks at incoming pulses as well as the held flag.
    assign jt_new = take_action_ocimem_b | take_no_action_ocimem_a |
                    (take_action_ocimem_a & jdo_rd(jdo));
    assign av_req = chipselect & (read | write);

    // jdo bits outside the address/data/read-flag fields carry other debug commands.
    assign jdo_unused = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LO-1:0]};

    // Non-debug masters read zero; readdata is live during AV_DONE, then held.
    assign av_rdata = av_dbg ? ram_rdata : '0;
    assign readdata = (state == ST_AV_DONE && !av_wr) ? av_rdata : rd_hold;

    // RAM port steering: JTAG owns it in JT_OP, Avalon in AV_OP.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = jtag_addr;
        ram_wdata = MonDReg;
        unique case (state)
            ST_JT_OP: begin
                ram_en    = 1'b1;
                ram_we    = jt_pend_wr;
                ram_be    = '1;
                ram_addr  = jtag_addr;
                ram_wdata = MonDReg;
            end
            ST_AV_OP: begin
                ram_en    = 1'b1;
                ram_we    = av_wr & av_dbg;
                ram_be    = av_be;
                ram_addr  = av_addr;
                ram_wdata = av_wdata;
            end
            default: ;
        endcase
    end

    dbg_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Arbitration FSM plus JTAG request capture; pulses are applied last so a
    // new pulse overrides whatever the FSM did to the same register this cycle.
    // NOTE: non-blocking assignments only here, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            jtag_addr     <= '0;
            jt_pend       <= 1'b0;
            jt_pend_wr    <= 1'b0;
            jt_op_rd      <= 1'b0;
            av_addr       <= '0;
            av_wr         <= 1'b0;
            av_dbg        <= 1'b0;
            av_be         <= '0;
            av_wdata      <= '0;
            rd_hold       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            waitrequest   <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (jt_pend || jt_new) begin
                        state <= ST_JT_OP;
                    end else if (av_req) begin
                        state    <= ST_AV_OP;
                        av_addr  <= address;
                        av_wr    <= write;
                        av_dbg   <= debugaccess;
                        av_be    <= byteenable;
                        av_wdata <= writedata;
                    end
                end
                // The request is consumed as the RAM captures it, so a pulse
                // landing during JT_OP/JT_DONE becomes the next request.
                ST_JT_OP: begin
                    state     <= ST_JT_DONE;
                    jt_op_rd  <= !jt_pend_wr;
                    jt_pend   <= 1'b0;
                    jtag_addr <= jtag_addr + ADDR_W'(1);
                end
                ST_JT_DONE: begin
                    state <= ST_IDLE;
                    if (jt_op_rd) begin
                        MonDReg       <= ram_rdata;
                        monitor_ready <= 1'b1;
                    end
                end
                ST_AV_OP: begin
                    state       <= ST_AV_DONE;
                    waitrequest <= 1'b0;
                end
                ST_AV_DONE: begin
                    state       <= ST_IDLE;
                    waitrequest <= 1'b1;
                    if (!av_wr) begin
                        rd_hold <= av_rdata;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    waitrequest <= 1'b1;
                end
            endcase

            if (take_action_ocimem_a) begin
                jtag_addr     <= ADDR_W'(jdo_addr(jdo));
                monitor_ready <= 1'b0;
                if (jdo_rd(jdo)) begin
                    jt_pend    <= 1'b1;
                    jt_pend_wr <= 1'b0;
                end
            end
            if (take_no_action_ocimem_a) begin
                jt_pend       <= 1'b1;
                jt_pend_wr    <= 1'b0;
                monitor_ready <= 1'b0;
            end
            if (take_action_ocimem_b) begin
                MonDReg    <= jdo_data(jdo);
                jt_pend    <= 1'b1;
                jt_pend_wr <= 1'b1;
            end
        end
    end

endmodule
